// File: rtl/gcd_driver_if.sv
// gcd_driver_if: operand stream, engine port and result stream bundle for gcd_driver
interface gcd_driver_if #(
  parameter int XLEN = 32,
  parameter int CNT_W = 16
);
  logic in_valid_i;
  logic in_ready_o;
  logic [XLEN-1:0] in_a_i;
  logic [XLEN-1:0] in_b_i;
  logic eng_ld_o;
  logic [XLEN-1:0] eng_a_o;
  logic [XLEN-1:0] eng_b_o;
  logic eng_ready_i;
  logic eng_valid_i;
  logic [XLEN-1:0] eng_gcd_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [XLEN-1:0] out_gcd_o;
  logic [CNT_W-1:0] out_cycles_o;
  logic out_err_o;
  logic busy_o;
  logic [31:0] ops_done_o;
  modport master (
    input in_valid_i, in_a_i, in_b_i, eng_ready_i, eng_valid_i, eng_gcd_i, out_ready_i,
    output in_ready_o, eng_ld_o, eng_a_o, eng_b_o, out_valid_o, out_gcd_o, out_cycles_o,
    output out_err_o, busy_o, ops_done_o
  );
  modport slave (
    output in_valid_i, in_a_i, in_b_i, eng_ready_i, eng_valid_i, eng_gcd_i, out_ready_i,
    input in_ready_o, eng_ld_o, eng_a_o, eng_b_o, out_valid_o, out_gcd_o, out_cycles_o,
    input out_err_o, busy_o, ops_done_o
  );
endinterface

// File: rtl/gcd_driver.sv
// gcd_driver: buffers operand pairs, issues them to the gcd engine and returns timed results
module gcd_driver #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 65535
) (
  input logic clk_i,
  input logic resetn_i,
  gcd_driver_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;
  logic [XLEN-1:0] mem_a [DEPTH];
  logic [XLEN-1:0] mem_b [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [CNT_W-1:0] cyc;
  logic push, pop, done, tmo, empty;
  assign empty = count == '0;
  assign bus.in_ready_o = count != (PW+1)'(DEPTH);
  assign push = bus.in_valid_i && bus.in_ready_o;
  assign tmo = cyc == CNT_W'(TIMEOUT);
  assign done = state == WAIT && (bus.eng_valid_i || tmo);
  assign bus.busy_o = state != IDLE || !empty;
  always_ff @(posedge clk_i) begin
    if (!resetn_i) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE  ? (!empty && !bus.out_valid_o ? ISSUE : IDLE) :
                state == ISSUE ? (bus.eng_ready_i ? WAIT : ISSUE) :
                state == WAIT  ? (done ? IDLE : WAIT) : IDLE;
  end
  always_comb begin
    pop = state == ISSUE && bus.eng_ready_i;
    bus.eng_ld_o = pop;
    bus.eng_a_o = state == ISSUE ? mem_a[rd_ptr] : '0;
    bus.eng_b_o = state == ISSUE ? mem_b[rd_ptr] : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_a[wr_ptr] <= bus.in_a_i;
        mem_b[wr_ptr] <= bus.in_b_i;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (!resetn_i) cyc <= '0;
    else if (pop) cyc <= CNT_W'(1);
    else if (state == WAIT && cyc != '1) cyc <= cyc + CNT_W'(1);
  end
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      bus.out_valid_o <= 1'b0;
      bus.out_gcd_o <= '0;
      bus.out_cycles_o <= '0;
      bus.out_err_o <= 1'b0;
      bus.ops_done_o <= '0;
    end else if (done) begin
      bus.out_valid_o <= 1'b1;
      bus.out_gcd_o <= bus.eng_valid_i ? bus.eng_gcd_i : '0;
      bus.out_cycles_o <= bus.eng_valid_i ? cyc : CNT_W'(TIMEOUT);
      bus.out_err_o <= !bus.eng_valid_i;
      bus.ops_done_o <= bus.ops_done_o + 32'd1;
    end else if (bus.out_valid_o && bus.out_ready_i) begin
      bus.out_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gcd_driver.sv
// tb_gcd_driver: randomized self-checking bench for gcd_driver with an engine model and result scoreboard
module tb_gcd_driver;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int TO = 20;
  typedef struct { logic [XLEN-1:0] a; logic [XLEN-1:0] b; int lat; } op_t;
  typedef struct { logic [XLEN-1:0] g; logic [CNT_W-1:0] c; logic e; } res_t;
  logic clk_i = 1'b0;
  logic resetn_i = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int n_pushed = 0;
  op_t op_q[$];
  res_t exp_q[$];
  logic sink_rdy = 1'b1;
  logic rnd_out = 1'b0;
  logic ld_q = 1'b0;
  logic [XLEN-1:0] a_q, b_q, res;
  int timer = 0;
  gcd_driver_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  gcd_driver #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk_i(clk_i),
    .resetn_i(resetn_i),
    .bus(bus.master)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [XLEN-1:0] gcd_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  task automatic push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int lat);
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.in_a_i = a;
    bus.in_b_i = b;
    while (!bus.in_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) begin
      check("push_timeout", 1, 0);
      bus.in_valid_i = 1'b0;
      return;
    end
    op_q.push_back('{a: a, b: b, lat: lat});
    exp_q.push_back(lat == 0 ? '{g: '0, c: CNT_W'(TO), e: 1'b1} : '{g: gcd_ref(a, b), c: CNT_W'(lat), e: 1'b0});
    n_pushed++;
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 1, 0);
    @(negedge clk_i);
  endtask
  always_ff @(posedge clk_i) begin
    ld_q <= bus.eng_ld_o;
    a_q <= bus.eng_a_o;
    b_q <= bus.eng_b_o;
  end
  always @(negedge clk_i) begin
    op_t op;
    bus.eng_valid_i = 1'b0;
    bus.eng_gcd_i = $urandom();
    if (ld_q) begin
      if (op_q.size() == 0) check("eng_spurious_ld", 1, 0);
      else begin
        op = op_q.pop_front();
        check("eng_a", a_q, op.a);
        check("eng_b", b_q, op.b);
        timer = op.lat == 0 ? -1 : op.lat;
        res = gcd_ref(a_q, b_q);
      end
    end
    if (timer > 0) begin
      timer--;
      if (timer == 0) begin
        bus.eng_valid_i = 1'b1;
        bus.eng_gcd_i = res;
      end
    end
  end
  always @(negedge clk_i) begin
    res_t r;
    bus.out_ready_i = rnd_out ? ($urandom_range(0, 2) != 0) : sink_rdy;
    if (resetn_i && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) check("spurious_result", 1, 0);
      else begin
        r = exp_q.pop_front();
        check("out_gcd", bus.out_gcd_o, r.g);
        check("out_cycles", bus.out_cycles_o, r.c);
        check("out_err", bus.out_err_o, r.e);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    int bad;
    bus.in_valid_i = 1'b0;
    bus.in_a_i = '0;
    bus.in_b_i = '0;
    bus.eng_ready_i = 1'b1;
    resetn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_in_ready", bus.in_ready_o, 1);
    check("rst_busy", bus.busy_o, 0);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_ops_done", bus.ops_done_o, 0);
    check("rst_eng_ld", bus.eng_ld_o, 0);
    check("rst_eng_a", bus.eng_a_o, 0);
    check("rst_out_gcd", bus.out_gcd_o, 0);
    check("rst_out_cycles", bus.out_cycles_o, 0);
    check("rst_out_err", bus.out_err_o, 0);
    resetn_i = 1'b1;
    @(negedge clk_i);
    push(48, 18, 5);
    check("lat_ld_early", bus.eng_ld_o, 0);
    @(negedge clk_i);
    check("lat_ld", bus.eng_ld_o, 1);
    check("lat_eng_a", bus.eng_a_o, 48);
    check("lat_eng_b", bus.eng_b_o, 18);
    drain();
    check("ops_done_1", bus.ops_done_o, 1);
    bus.eng_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) push(XLEN'(7 * i), XLEN'(21 * i), 3);
    check("full_in_ready", bus.in_ready_o, 0);
    check("full_busy", bus.busy_o, 1);
    repeat (3) begin
      @(negedge clk_i);
      check("full_hold", bus.in_ready_o, 0);
      check("stall_no_ld", bus.eng_ld_o, 0);
    end
    bus.eng_ready_i = 1'b1;
    push(35, 105, 3);
    drain();
    sink_rdy = 1'b0;
    push(100, 75, 2);
    push(81, 27, 2);
    n = 0;
    while (!bus.out_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) check("out_valid_timeout", 1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("hold_valid", bus.out_valid_o, 1);
      check("hold_no_ld", bus.eng_ld_o, 0);
      if (exp_q.size() != 0) begin
        check("hold_gcd", bus.out_gcd_o, exp_q[0].g);
        check("hold_cycles", bus.out_cycles_o, exp_q[0].c);
        check("hold_err", bus.out_err_o, exp_q[0].e);
      end
    end
    @(posedge clk_i);
    #1 sink_rdy = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("post_clear_no_ld", bus.eng_ld_o, 0);
    @(negedge clk_i);
    check("post_clear_ld", bus.eng_ld_o, 1);
    drain();
    push(30, 12, 0);
    push(21, 14, 4);
    drain();
    check("ops_done_timeout", bus.ops_done_o, 32'(n_pushed));
    bus.eng_ready_i = 1'b0;
    push(60, 45, 15);
    push(16, 24, 2);
    @(negedge clk_i);
    bus.eng_ready_i = 1'b1;
    push(9, 6, 2);
    bus.eng_ready_i = 1'b0;
    check("pushpop_room_a", bus.in_ready_o, 1);
    push(10, 4, 2);
    check("pushpop_room_b", bus.in_ready_o, 1);
    push(44, 33, 2);
    check("pushpop_full", bus.in_ready_o, 0);
    bus.eng_ready_i = 1'b1;
    drain();
    rnd_out = 1'b1;
    for (int k = 1; k <= 10; k++) push(XLEN'(3 * k), XLEN'(5 * k), $urandom_range(1, 6));
    drain();
    for (int i = 0; i < 40; i++) begin
      logic [XLEN-1:0] g;
      g = XLEN'($urandom_range(1, 50));
      push(g * XLEN'($urandom_range(0, 40)), g * XLEN'($urandom_range(0, 40)),
           $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 19));
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    drain();
    rnd_out = 1'b0;
    check("ops_done_total", bus.ops_done_o, 32'(n_pushed));
    push(60, 40, 15);
    push(1, 1, 3);
    push(2, 2, 3);
    push(3, 3, 3);
    @(negedge clk_i);
    resetn_i = 1'b0;
    @(negedge clk_i);
    resetn_i = 1'b1;
    op_q.delete();
    exp_q.delete();
    n_pushed = 0;
    check("mid_rst_in_ready", bus.in_ready_o, 1);
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_out_valid", bus.out_valid_o, 0);
    check("mid_rst_ops_done", bus.ops_done_o, 0);
    check("mid_rst_eng_ld", bus.eng_ld_o, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (bus.eng_ld_o || bus.out_valid_o) bad++;
    end
    check("mid_rst_quiet", bad, 0);
    check("mid_rst_ops_hold", bus.ops_done_o, 0);
    push(48, 18, 5);
    drain();
    check("post_rst_ops_done", bus.ops_done_o, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gcd_driver.md
Name: gcd_driver

Overview:
- Initiator-side front end for the gcd engine.
- Buffers operand pairs from an upstream valid/ready stream and issues them one at a time over the engine's ld/ready/valid interface.
- Captures each result together with its measured cycle latency and presents it on a downstream valid/ready stream.
- Sits between a workload source (testbench, Verilator harness or core) and the gcd engine, and is the cycle-accounting point for workload runs.

Parameters:
- XLEN, 32, operand/result width; must match the engine.
- DEPTH, 4, input FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the per-operation cycle counter.
- TIMEOUT, 65535, maximum cycles to wait for the engine's eng_valid_i before aborting; must be < 2^CNT_W.

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- resetn_i  in  1  synchronous active-low reset.
- in_valid_i  in  1  upstream operand pair valid.
- in_ready_o  out  1  FIFO not full.
- in_a_i  in  XLEN  operand A.
- in_b_i  in  XLEN  operand B.
- eng_ld_o  out  1  load strobe to engine.
- eng_a_o  out  XLEN  operand A to engine.
- eng_b_o  out  XLEN  operand B to engine.
- eng_ready_i  in  1  engine idle, can accept a load.
- eng_valid_i  in  1  engine result strobe, one cycle.
- eng_gcd_i  in  XLEN  engine result, valid when eng_valid_i = 1.
- out_valid_o  out  1  result slot full.
- out_ready_i  in  1  downstream accepts the result.
- out_gcd_o  out  XLEN  result.
- out_cycles_o  out  CNT_W  latency of this operation.
- out_err_o  out  1  this result is a timeout abort.
- busy_o  out  1  FSM not IDLE or FIFO non-empty.
- ops_done_o  out  32  count of results produced; wraps.

Behaviour:
- Reset (resetn_i low at an edge):
  - FSM to IDLE, FIFO emptied, result slot emptied, counters to 0.
  - Outputs: in_ready_o = 1 once resetn_i is high; all other outputs 0.
  - Reset mid-operation abandons the in-flight op. Any eng_valid_i seen in IDLE is ignored.
- Input FIFO:
  - Push on in_valid_i & in_ready_o.
  - in_ready_o = !full, purely from registered count; no combinational path from in_valid_i.
  - Push when full is impossible.
  - Push and pop in the same cycle is legal at any non-full occupancy; count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, WAIT:
  - IDLE -> ISSUE when FIFO non-empty and result slot empty (out_valid_o = 0). Issue is blocked while a result is pending, so an engine result strobe can never be lost.
  - ISSUE: eng_a_o/eng_b_o = FIFO head. eng_ld_o = eng_ready_i.
    - If eng_ready_i = 1: pop FIFO, clear cycle counter to 1, go to WAIT.
    - Otherwise hold ISSUE (stall, no pop).
  - WAIT: counter increments each cycle, saturating at all-ones.
    - On eng_valid_i: load slot with out_gcd_o = eng_gcd_i, out_cycles_o = counter, out_err_o = 0. Set out_valid_o, increment ops_done_o, go to IDLE.
    - If counter reaches TIMEOUT without eng_valid_i: load slot with gcd = 0, cycles = TIMEOUT, err = 1. Set out_valid_o, increment ops_done_o, go to IDLE.
- Cycle count definition:
  - Number of edges from the ld edge to the eng_valid_i edge.
  - eng_valid_i in the cycle immediately after ld gives out_cycles_o = 1.
- Output slot:
  - Holds all fields stable while out_valid_o & !out_ready_i.
  - Clears on out_valid_o & out_ready_i.
  - The next issue can occur in the cycle after the clear.
- Latency: with idle engine, empty FIFO and empty slot, an input handshake at edge k gives eng_ld_o high in the cycle between edges k+1 and k+2.
- Operands are passed unmodified, including zero values; the driver does not interpret them.
- eng_ld_o is never asserted outside ISSUE and never asserted when eng_ready_i = 0.

Test Plan:
- Reset with FIFO holding 3 pairs and op in WAIT -> after reset: in_ready_o = 1, busy_o = 0, out_valid_o = 0, ops_done_o = 0, no eng_ld_o; a late eng_valid_i is ignored.
- Single pair (48, 18), engine model returns 6 after 5 cycles -> eng_ld_o exactly 2 cycles after the handshake; out_gcd_o = 6, out_cycles_o = 5, out_err_o = 0, ops_done_o = 1.
- Push 5 pairs back-to-back with DEPTH = 4 and engine eng_ready_i held low -> in_ready_o drops after 4 accepted; 5th accepted only after the first pop; results emerge in order.
- out_ready_i held low for 10 cycles with FIFO non-empty -> out_* fields stable throughout; no eng_ld_o until 1 cycle after the output handshake.
- Engine never asserts eng_valid_i, TIMEOUT = 20 -> out_err_o = 1, out_gcd_o = 0, out_cycles_o = 20; next pair issues normally afterward.
- Simultaneous push and pop at count 2 -> count stays 2; pointer wrap verified across 10 ops with results (1..10) in order.
